// File: rtl/birukee_dma32_mem_responder_if.sv
// Bundles the 32-bit accelerator DMA handshake signals (read/write ctrl and
// read/write data channels) between an accelerator and a memory responder.
//   master : accelerator side (issues ctrl requests, sinks read data, sources write data)
//   slave  : memory responder side
interface birukee_dma32_mem_responder_if;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready;
    logic [31:0] dma_read_chnl_data;

    logic        dma_write_ctrl_valid;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_chnl_valid;
    logic        dma_write_chnl_ready;
    logic [31:0] dma_write_chnl_data;

    modport master (
        output dma_read_ctrl_valid, dma_read_ctrl_data_index,
               dma_read_ctrl_data_length, dma_read_ctrl_data_size,
        input  dma_read_ctrl_ready,
        input  dma_read_chnl_valid, dma_read_chnl_data,
        output dma_read_chnl_ready,
        output dma_write_ctrl_valid, dma_write_ctrl_data_index,
               dma_write_ctrl_data_length, dma_write_ctrl_data_size,
        input  dma_write_ctrl_ready,
        output dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_write_chnl_ready
    );

    modport slave (
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index,
               dma_read_ctrl_data_length, dma_read_ctrl_data_size,
        output dma_read_ctrl_ready,
        output dma_read_chnl_valid, dma_read_chnl_data,
        input  dma_read_chnl_ready,
        input  dma_write_ctrl_valid, dma_write_ctrl_data_index,
               dma_write_ctrl_data_length, dma_write_ctrl_data_size,
        output dma_write_ctrl_ready,
        input  dma_write_chnl_valid, dma_write_chnl_data,
        output dma_write_chnl_ready
    );
endinterface

// File: rtl/birukee_dma32_mem_responder.sv
// Memory-side responder for the 32-bit accelerator DMA interface. Holds a
// 2**ADDR_W x 32 word array, streams read bursts out and absorbs write bursts in.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset (array contents are not reset)
//   dma            DMA ctrl/chnl bundle (slave modport)
//   bd_we/bd_addr/bd_wdata  backdoor write port; bd_rdata combinational mem[bd_addr]
//   busy           a burst is in progress
//   err_size       sticky flag: a request with size != 32-bit was accepted
// Optional feature: define BIRUKEE_DMA_RESP_STATS_EN to add stat_rd_beats,
// stat_wr_beats and stat_reqs counters (wrap on overflow).
module birukee_dma32_mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    birukee_dma32_mem_responder_if.slave dma,
    input  logic                         bd_we,
    input  logic [ADDR_W-1:0]            bd_addr,
    input  logic [31:0]                  bd_wdata,
    output logic [31:0]                  bd_rdata,
    output logic                         busy,
    output logic                         err_size
`ifdef BIRUKEE_DMA_RESP_STATS_EN
    ,
    output logic [31:0]                  stat_rd_beats,
    output logic [31:0]                  stat_wr_beats,
    output logic [15:0]                  stat_reqs
`endif
);

    localparam logic [2:0] SIZE_WORD = 3'b010;
    localparam int         DEPTH     = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         remaining_q, remaining_d;
    logic                rr_last_q, rr_last_d;   // 1: last grant was a write
    logic                err_size_q, err_size_d;

    logic [31:0]         mem [DEPTH];

    logic                rd_grant, wr_grant;
    logic                rd_fire, wr_fire;
    logic                unused_index_bits;

    // Round-robin arbitration in IDLE; a lone request always wins.
    assign rd_grant = (state_q == IDLE) && dma.dma_read_ctrl_valid &&
                      (!dma.dma_write_ctrl_valid || rr_last_q);
    assign wr_grant = (state_q == IDLE) && dma.dma_write_ctrl_valid &&
                      (!dma.dma_read_ctrl_valid || !rr_last_q);

    assign rd_fire = (state_q == RD) && dma.dma_read_chnl_ready;
    assign wr_fire = (state_q == WR) && dma.dma_write_chnl_valid;

    // Index bits above the array width are ignored (addresses wrap).
    assign unused_index_bits = ^{dma.dma_read_ctrl_data_index[31:ADDR_W],
                                 dma.dma_write_ctrl_data_index[31:ADDR_W]};

    // Ctrl ready is gated by the grant so only one handshake completes per
    // cycle when both sides request; held low while reset is asserted.
    assign dma.dma_read_ctrl_ready  = rst && rd_grant;
    assign dma.dma_write_ctrl_ready = rst && wr_grant;
    assign dma.dma_read_chnl_valid  = (state_q == RD);
    assign dma.dma_read_chnl_data   = mem[addr_q];
    assign dma.dma_write_chnl_ready = (state_q == WR);

    assign bd_rdata = mem[bd_addr];
    assign busy     = (state_q != IDLE);
    assign err_size = err_size_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rr_last_q   <= 1'b1;
            err_size_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rr_last_q   <= rr_last_d;
            err_size_q  <= err_size_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        rr_last_d   = rr_last_q;
        err_size_d  = err_size_q;
        case (state_q)
            IDLE: begin
                if (rd_grant) begin
                    addr_d      = dma.dma_read_ctrl_data_index[ADDR_W-1:0];
                    remaining_d = dma.dma_read_ctrl_data_length;
                    rr_last_d   = 1'b0;
                    if (dma.dma_read_ctrl_data_size != SIZE_WORD) err_size_d = 1'b1;
                    if (dma.dma_read_ctrl_data_length != 32'd0)   state_d = RD;
                end else if (wr_grant) begin
                    addr_d      = dma.dma_write_ctrl_data_index[ADDR_W-1:0];
                    remaining_d = dma.dma_write_ctrl_data_length;
                    rr_last_d   = 1'b1;
                    if (dma.dma_write_ctrl_data_size != SIZE_WORD) err_size_d = 1'b1;
                    if (dma.dma_write_ctrl_data_length != 32'd0)   state_d = WR;
                end
            end
            RD, WR: begin
                if (rd_fire || wr_fire) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The DMA write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (bd_we)   mem[bd_addr] <= bd_wdata;
        if (wr_fire) mem[addr_q]  <= dma.dma_write_chnl_data;
    end

`ifdef BIRUKEE_DMA_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rd_beats <= '0;
            stat_wr_beats <= '0;
            stat_reqs     <= '0;
        end else begin
            if (rd_fire)              stat_rd_beats <= stat_rd_beats + 32'd1;
            if (wr_fire)              stat_wr_beats <= stat_wr_beats + 32'd1;
            if (rd_grant || wr_grant) stat_reqs     <= stat_reqs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_birukee_dma32_mem_responder.sv
// Self-checking bench for birukee_dma32_mem_responder (ADDR_W = 10).
module tb_birukee_dma32_mem_responder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [31:0]       bd_wdata = '0;
    logic [31:0]       bd_rdata;
    logic              busy;
    logic              err_size;
`ifdef BIRUKEE_DMA_RESP_STATS_EN
    logic [31:0]       stat_rd_beats;
    logic [31:0]       stat_wr_beats;
    logic [15:0]       stat_reqs;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];

    birukee_dma32_mem_responder_if dma_if ();

    birukee_dma32_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .dma      (dma_if),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata),
        .busy     (busy),
        .err_size (err_size)
`ifdef BIRUKEE_DMA_RESP_STATS_EN
        ,
        .stat_rd_beats (stat_rd_beats),
        .stat_wr_beats (stat_wr_beats),
        .stat_reqs     (stat_reqs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] idx;
        int          len;
        logic [31:0] exp [4];
    } rd_vec_t;

    rd_vec_t vecs [5];

    function automatic rd_vec_t mk(input logic [31:0] idx, input int len,
                                   input logic [31:0] e0, input logic [31:0] e1,
                                   input logic [31:0] e2, input logic [31:0] e3);
        rd_vec_t v;
        v.idx = idx; v.len = len;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic bd_check(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        @(negedge clk);
        bd_addr = a;
        #1 chk(name, bd_rdata, exp);
    endtask

    task automatic rd_req(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
        int n;
        @(negedge clk);
        dma_if.dma_read_ctrl_valid       = 1'b1;
        dma_if.dma_read_ctrl_data_index  = idx;
        dma_if.dma_read_ctrl_data_length = len;
        dma_if.dma_read_ctrl_data_size   = sz;
        #1;
        n = 0;
        while (!dma_if.dma_read_ctrl_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) chk("rd_ctrl_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        dma_if.dma_read_ctrl_valid = 1'b0;
    endtask

    task automatic wr_req(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
        int n;
        @(negedge clk);
        dma_if.dma_write_ctrl_valid       = 1'b1;
        dma_if.dma_write_ctrl_data_index  = idx;
        dma_if.dma_write_ctrl_data_length = len;
        dma_if.dma_write_ctrl_data_size   = sz;
        #1;
        n = 0;
        while (!dma_if.dma_write_ctrl_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) chk("wr_ctrl_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        dma_if.dma_write_ctrl_valid = 1'b0;
    endtask

    // Expects one beat per cycle starting the cycle after the ctrl handshake,
    // then the responder back in IDLE.
    task automatic collect_read(input int n);
        rd_q.delete();
        dma_if.dma_read_chnl_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            chk("rd_beat_valid", {31'd0, dma_if.dma_read_chnl_valid}, 32'd1);
            rd_q.push_back(dma_if.dma_read_chnl_data);
        end
        @(negedge clk); #1;
        chk("rd_valid_after_burst", {31'd0, dma_if.dma_read_chnl_valid}, 32'd0);
        chk("busy_after_read", {31'd0, busy}, 32'd0);
        dma_if.dma_read_chnl_ready = 1'b0;
    endtask

    task automatic wr_beat(input logic [31:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            dma_if.dma_write_chnl_valid = 1'b0;
        end
        @(negedge clk);
        dma_if.dma_write_chnl_valid = 1'b1;
        dma_if.dma_write_chnl_data  = d;
        #1 chk("wr_chnl_ready", {31'd0, dma_if.dma_write_chnl_ready}, 32'd1);
        @(posedge clk); #1;
        dma_if.dma_write_chnl_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stall_exp [5];
        logic        stall_rdy [5];

        dma_if.dma_read_ctrl_valid        = 1'b0;
        dma_if.dma_read_ctrl_data_index   = '0;
        dma_if.dma_read_ctrl_data_length  = '0;
        dma_if.dma_read_ctrl_data_size    = 3'b010;
        dma_if.dma_read_chnl_ready        = 1'b0;
        dma_if.dma_write_ctrl_valid       = 1'b0;
        dma_if.dma_write_ctrl_data_index  = '0;
        dma_if.dma_write_ctrl_data_length = '0;
        dma_if.dma_write_ctrl_data_size   = 3'b010;
        dma_if.dma_write_chnl_valid       = 1'b0;
        dma_if.dma_write_chnl_data        = '0;

        // Reset state, with a read request pending to prove ready stays low.
        dma_if.dma_read_ctrl_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_ctrl_ready", {31'd0, dma_if.dma_read_ctrl_ready}, 32'd0);
        chk("rst_wr_ctrl_ready", {31'd0, dma_if.dma_write_ctrl_ready}, 32'd0);
        chk("rst_rd_chnl_valid", {31'd0, dma_if.dma_read_chnl_valid}, 32'd0);
        chk("rst_wr_chnl_ready", {31'd0, dma_if.dma_write_chnl_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err_size", {31'd0, err_size}, 32'd0);
        dma_if.dma_read_ctrl_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Both ctrl valid, length 0: grants must alternate read, write, read.
        @(negedge clk);
        dma_if.dma_read_ctrl_valid  = 1'b1;
        dma_if.dma_write_ctrl_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("arb_rd_ready", {31'd0, dma_if.dma_read_ctrl_ready}, (k != 1) ? 32'd1 : 32'd0);
            chk("arb_wr_ready", {31'd0, dma_if.dma_write_ctrl_ready}, (k == 1) ? 32'd1 : 32'd0);
            chk("arb_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #1;
        dma_if.dma_read_ctrl_valid  = 1'b0;
        dma_if.dma_write_ctrl_valid = 1'b0;
        @(negedge clk); #1;
        chk("len0_no_beat", {31'd0, dma_if.dma_read_chnl_valid}, 32'd0);

        // Preload.
        for (int i = 0; i < 4; i++) bd_write(ADDR_W'(i), 32'hA0 + 32'(i));
        bd_write(ADDR_W'(1023), 32'hDEAD_BEEF);
        bd_write(ADDR_W'(11), 32'h0BAD_0011);

        // Write burst with valid gaps.
        wr_req(32'd8, 32'd3, 3'b010);
        wr_beat(32'h11, 0);
        wr_beat(32'h22, 1);
        wr_beat(32'h33, 2);
        @(negedge clk); #1;
        chk("busy_after_write", {31'd0, busy}, 32'd0);
        chk("wr_ready_after_write", {31'd0, dma_if.dma_write_chnl_ready}, 32'd0);
        bd_check("bd_mem8", ADDR_W'(8), 32'h11);
        bd_check("bd_mem9", ADDR_W'(9), 32'h22);
        bd_check("bd_mem10", ADDR_W'(10), 32'h33);
        bd_check("bd_mem11_untouched", ADDR_W'(11), 32'h0BAD_0011);

        // Table-driven read bursts.
        vecs[0] = mk(32'd0,         4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vecs[1] = mk(32'd1023,      2, 32'hDEAD_BEEF, 32'hA0, 32'h0, 32'h0);
        vecs[2] = mk(32'd8,         3, 32'h11, 32'h22, 32'h33, 32'h0);
        vecs[3] = mk(32'hFFFF_FC01, 2, 32'hA1, 32'hA2, 32'h0, 32'h0);
        vecs[4] = mk(32'd2,         1, 32'hA2, 32'h0, 32'h0, 32'h0);
        for (int v = 0; v < 5; v++) begin
            rd_req(vecs[v].idx, 32'(vecs[v].len), 3'b010);
            collect_read(vecs[v].len);
            for (int j = 0; j < vecs[v].len; j++)
                chk($sformatf("rd_vec%0d_beat%0d", v, j), rd_q[j], vecs[v].exp[j]);
        end

        // Read with consumer stalls: ready 1,0,0,1,1.
        stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        stall_exp = '{32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2};
        rd_req(32'd0, 32'd3, 3'b010);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dma_if.dma_read_chnl_ready = stall_rdy[c];
            #1;
            chk($sformatf("stall_valid%0d", c), {31'd0, dma_if.dma_read_chnl_valid}, 32'd1);
            chk($sformatf("stall_data%0d", c), dma_if.dma_read_chnl_data, stall_exp[c]);
        end
        @(negedge clk);
        dma_if.dma_read_chnl_ready = 1'b1;
        #1 chk("stall_no_4th_beat", {31'd0, dma_if.dma_read_chnl_valid}, 32'd0);
        dma_if.dma_read_chnl_ready = 1'b0;

        // Unsupported size: served as words, flag sticks.
        rd_req(32'd3, 32'd1, 3'b011);
        collect_read(1);
        chk("bad_size_data", rd_q[0], 32'hA3);
        chk("err_size_set", {31'd0, err_size}, 32'd1);
        repeat (3) @(negedge clk);
        #1 chk("err_size_sticky", {31'd0, err_size}, 32'd1);

        // Reset in the middle of a write burst.
        wr_req(32'd20, 32'd4, 3'b010);
        wr_beat(32'h77, 0);
        wr_beat(32'h88, 0);
        @(negedge clk);
        dma_if.dma_write_chnl_valid = 1'b1;
        dma_if.dma_write_chnl_data  = 32'h99;
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_wr_chnl_ready", {31'd0, dma_if.dma_write_chnl_ready}, 32'd0);
        chk("midrst_err_size", {31'd0, err_size}, 32'd0);
        @(posedge clk); #1;
        dma_if.dma_write_chnl_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 chk("after_rst_wr_chnl_ready", {31'd0, dma_if.dma_write_chnl_ready}, 32'd0);
        rd_req(32'd20, 32'd2, 3'b010);
        collect_read(2);
        chk("partial_word20", rd_q[0], 32'h77);
        chk("partial_word21", rd_q[1], 32'h88);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
